// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the forwarding scoreboard: the per-stage entry,
// the register-file select value, and parameter legality checks.
package fwd_scoreboard_pkg;

  localparam int SB_AW_MAX = 8;
  localparam int FWD_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic                 load;
    logic [SB_AW_MAX-1:0] dst;
  } sb_entry_t;

  function automatic bit depth_ok(int depth);
    return (depth >= 2) && (depth <= 8);
  endfunction

  function automatic bit load_stage_ok(int ls, int depth);
    return (ls >= 1) && (ls <= depth - 1);
  endfunction

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic entry_hit(sb_entry_t e, logic [SB_AW_MAX-1:0] src);
    return e.valid && e.wr && (e.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forward selection: youngest matching producer in stages 1..DEPTH-1,
// skipping loads whose data is not yet available (flagged as load_haz).
module fwd_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 4,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  logic [REG_AW-1:0]     src,
  input  sb_entry_t [DEPTH-1:0] ent,
  output logic [SEL_W-1:0]      sel,
  output logic                  load_haz
);

  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_haz = 1'b0;
    // Walk oldest to youngest so the youngest usable match overwrites.
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (entry_hit(ent[k], SB_AW_MAX'(src))) begin
        if (ent[k].load && (k < LOAD_STAGE)) load_haz = 1'b1;
        else                                 sel      = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Pipeline scoreboard: tracks in-flight writers per stage, picks forwarding
// sources for the EX operands and stalls ID on load-use hazards.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 4,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_wr,
  input  logic                      id_load,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [15:0]               stall_cnt
);

  if (!depth_ok(DEPTH) || !load_stage_ok(LOAD_STAGE, DEPTH) || (REG_AW > SB_AW_MAX))
  begin : g_bad_params
    $error("fwd_scoreboard: illegal DEPTH/LOAD_STAGE/REG_AW combination");
  end

  sb_entry_t [DEPTH-1:0]       sb_q, sb_d;
  logic [NUM_SRC*REG_AW-1:0]   ex_src_q, ex_src_d;
  logic [15:0]                 stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC*SEL_W-1:0]    ex_sel;
  logic [NUM_SRC-1:0]          ex_haz;
  logic                        issue;

  // A load at stage k reaches LOAD_STAGE too late if the consumer would be in EX
  // while the load is still short of it, i.e. k+1 < LOAD_STAGE.
  always_comb begin
    stall = 1'b0;
    if (!rst && id_valid && !flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int k = 0; k + 1 < LOAD_STAGE; k++) begin
          if (sb_q[k].load && entry_hit(sb_q[k], SB_AW_MAX'(id_src[i*REG_AW +: REG_AW])))
            stall = 1'b1;
        end
      end
    end
  end

  assign issue = id_valid && !stall && !flush;

  always_comb begin
    sb_d = '0;
    if (issue) begin
      sb_d[0].valid = 1'b1;
      sb_d[0].wr    = id_wr;
      sb_d[0].load  = id_load;
      sb_d[0].dst   = SB_AW_MAX'(id_dst);
    end
    sb_d[1] = flush ? '0 : sb_q[0];
    for (int k = 2; k < DEPTH; k++) sb_d[k] = sb_q[k-1];
    ex_src_d    = issue ? id_src : '0;
    stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q        <= '0;
      ex_src_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      ex_src_q    <= ex_src_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    fwd_match #(
      .REG_AW    (REG_AW),
      .DEPTH     (DEPTH),
      .LOAD_STAGE(LOAD_STAGE),
      .SEL_W     (SEL_W)
    ) u_match (
      .src     (ex_src_q[i*REG_AW +: REG_AW]),
      .ent     (sb_q),
      .sel     (ex_sel[i*SEL_W +: SEL_W]),
      .load_haz(ex_haz[i])
    );
  end

  assign fwd_sel   = rst ? '0 : ex_sel;
  assign stall_cnt = stall_cnt_q;

  // The stall guarantees a consumer never reaches EX ahead of its load data.
  a_no_early_load: assert property (@(posedge clk) disable iff (rst) ex_haz == '0);

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench: directed pipeline scenarios plus randomized traffic
// checked against an issue-time history model; a deep instance covers saturation.
module tb_fwd_scoreboard;

  localparam int AW = 5, DEPTH = 4, LS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_wr = 1'b0, id_load = 1'b0, flush = 1'b0;
  logic [9:0]  id_src = '0;
  logic [4:0]  id_dst = '0;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;

  logic        s_rst = 1'b1;
  logic        s_id_valid = 1'b0, s_id_wr = 1'b0, s_id_load = 1'b0;
  logic [9:0]  s_id_src = '0;
  logic [4:0]  s_id_dst = '0;
  logic        s_stall;
  logic [5:0]  s_fwd_sel;
  logic [15:0] s_stall_cnt;

  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
    .id_wr(id_wr), .id_load(id_load), .flush(flush), .stall(stall),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.DEPTH(8), .LOAD_STAGE(7)) dut_deep (
    .clk(clk), .rst(s_rst), .id_valid(s_id_valid), .id_src(s_id_src), .id_dst(s_id_dst),
    .id_wr(s_id_wr), .id_load(s_id_load), .flush(1'b0), .stall(s_stall),
    .fwd_sel(s_fwd_sel), .stall_cnt(s_stall_cnt)
  );

  // Model: every issued instruction remembered with the cycle it entered EX;
  // its stage is simply (now - cyc).
  typedef struct { int cyc; bit wr; bit ld; int dst; int s0; int s1; } inst_t;
  inst_t hist[$];
  int now = 0, m_cnt = 0;

  function automatic int src_of(int i);
    return int'(id_src[i*AW +: AW]);
  endfunction

  function automatic bit exp_stall();
    int st;
    if (rst || !id_valid || flush) return 1'b0;
    foreach (hist[j]) begin
      st = now - hist[j].cyc;
      if (hist[j].ld && hist[j].wr && hist[j].dst != 0 && (st + 1 < LS) &&
          (hist[j].dst == src_of(0) || hist[j].dst == src_of(1))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_fwd(int i);
    int src, best, st;
    src = 0; best = 0;
    foreach (hist[j]) if (hist[j].cyc == now) src = (i == 0) ? hist[j].s0 : hist[j].s1;
    if (src == 0) return 0;
    foreach (hist[j]) begin
      st = now - hist[j].cyc;
      if (st >= 1 && st < DEPTH && hist[j].wr && hist[j].dst == src &&
          !(hist[j].ld && st < LS) && (best == 0 || st < best)) best = st;
    end
    return best;
  endfunction

  task automatic drive(bit v, int a, int b, int d, bit w, bit l, bit f);
    id_valid = v; id_src = {b[4:0], a[4:0]}; id_dst = d[4:0];
    id_wr = w; id_load = l; flush = f;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    bit s, iss;
    inst_t n;
    s   = exp_stall();
    iss = id_valid && !flush && !s;
    n.cyc = now + 1; n.wr = id_wr; n.ld = id_load; n.dst = int'(id_dst);
    n.s0 = src_of(0); n.s1 = src_of(1);
    if (flush)
      for (int j = hist.size() - 1; j >= 0; j--) if (hist[j].cyc == now) hist.delete(j);
    @(posedge clk);
    now++;
    if (iss) hist.push_back(n);
    if (s && m_cnt < 65535) m_cnt++;
    while (hist.size() > 0 && now - hist[0].cyc >= DEPTH) void'(hist.pop_front());
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    hist.delete(); now = 0; m_cnt = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2, 3, 4, 1'b1, 1'b1, 1'b0);
    #2;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall); else passed++;
    checks++; if (fwd_sel !== 4'h0) $display("FAIL reset_fwd: got %0h want 0", fwd_sel); else passed++;
    checks++; if (stall_cnt !== 16'h0) $display("FAIL reset_cnt: got %0h want 0", stall_cnt); else passed++;
  endtask

  task automatic test_raw_ex();
    do_reset();
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) $display("FAIL raw_add_stall: got %0b want 0", stall); else passed++;
    tick();
    drive(1'b1, 3, 5, 4, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) $display("FAIL raw_sub_stall: got %0b want 0", stall); else passed++;
    tick();
    idle(); #1;
    checks++; if (fwd_sel[1:0] !== 2'd1) $display("FAIL raw_fwd0: got %0d want 1", fwd_sel[1:0]); else passed++;
    checks++; if (fwd_sel[3:2] !== 2'd0) $display("FAIL raw_fwd1: got %0d want 0", fwd_sel[3:2]); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 0, 0, 2, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 2, 2, 6, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b1) $display("FAIL lu_stall_first: got %0b want 1", stall); else passed++;
    tick(); #1;
    checks++; if (stall !== 1'b0) $display("FAIL lu_stall_second: got %0b want 0", stall); else passed++;
    tick();
    idle(); #1;
    checks++; if (fwd_sel[1:0] !== 2'd2) $display("FAIL lu_fwd0: got %0d want 2", fwd_sel[1:0]); else passed++;
    checks++; if (fwd_sel[3:2] !== 2'd2) $display("FAIL lu_fwd1: got %0d want 2", fwd_sel[3:2]); else passed++;
    checks++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", stall_cnt); else passed++;
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1'b1, 1, 1, 7, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1, 1, 7, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 7, 0, 8, 1'b1, 1'b0, 1'b0); tick();
    idle(); #1;
    checks++; if (fwd_sel[1:0] !== 2'd1) $display("FAIL young_fwd0: got %0d want 1", fwd_sel[1:0]); else passed++;
    checks++; if (fwd_sel[3:2] !== 2'd0) $display("FAIL young_r0: got %0d want 0", fwd_sel[3:2]); else passed++;
  endtask

  task automatic test_distance();
    for (int gap = 2; gap <= 3; gap++) begin
      do_reset();
      drive(1'b1, 1, 1, 9, 1'b1, 1'b0, 1'b0); tick();
      for (int j = 0; j < gap; j++) begin idle(); tick(); end
      drive(1'b1, 9, 9, 10, 1'b1, 1'b0, 1'b0); tick();
      idle(); #1;
      checks++;
      if (fwd_sel !== ((gap == 2) ? 4'hF : 4'h0))
        $display("FAIL dist_gap%0d: got %0h want %0h", gap, fwd_sel, (gap == 2) ? 4'hF : 4'h0);
      else passed++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 0, 0, 2, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 2, 2, 6, 1'b1, 1'b0, 1'b1); #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_wins: got %0b want 0", stall); else passed++;
    tick();
    drive(1'b1, 2, 2, 6, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_load_gone: got %0b want 0", stall); else passed++;
    tick();
    idle(); #1;
    checks++; if (fwd_sel !== 4'h0) $display("FAIL flush_no_fwd: got %0h want 0", fwd_sel); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL flush_cnt: got %0d want 0", stall_cnt); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 0, 0, 2, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 2, 2, 6, 1'b1, 1'b0, 1'b0); tick(); tick();
    drive(1'b1, 6, 0, 3, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 3, 3, 7, 1'b1, 1'b0, 1'b0); #1;
    checks++; if (stall !== 1'b1) $display("FAIL mid_pre_stall: got %0b want 1", stall); else passed++;
    checks++; if (fwd_sel[1:0] !== 2'd1) $display("FAIL mid_pre_fwd: got %0d want 1", fwd_sel[1:0]); else passed++;
    checks++; if (stall_cnt !== 16'd1) $display("FAIL mid_pre_cnt: got %0d want 1", stall_cnt); else passed++;
    rst = 1'b1; #1;
    checks++; if (stall !== 1'b0) $display("FAIL mid_rst_stall: got %0b want 0", stall); else passed++;
    checks++; if (fwd_sel !== 4'h0) $display("FAIL mid_rst_fwd: got %0h want 0", fwd_sel); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL mid_rst_cnt: got %0d want 0", stall_cnt); else passed++;
    hist.delete(); now = 0; m_cnt = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 2, 3, 7, 1'b1, 1'b0, 1'b0); tick();
    idle(); #1;
    checks++; if (fwd_sel !== 4'h0) $display("FAIL mid_post_fwd: got %0h want 0", fwd_sel); else passed++;
  endtask

  task automatic test_random();
    bit v, w, l, f, held;
    int a, b, d;
    held = 1'b0; v = 1'b0; w = 1'b0; l = 1'b0; a = 0; b = 0; d = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        v = ($urandom_range(0, 9) < 8);
        a = $urandom_range(0, 5); b = $urandom_range(0, 5); d = $urandom_range(0, 5);
        w = ($urandom_range(0, 9) < 8); l = ($urandom_range(0, 9) < 4);
      end
      f = ($urandom_range(0, 9) == 0);
      drive(v, a, b, d, w, l, f); #1;
      checks++; if (stall !== exp_stall()) $display("FAIL rnd_stall c%0d: got %0b want %0b", c, stall, exp_stall()); else passed++;
      checks++; if (fwd_sel[1:0] !== 2'(exp_fwd(0))) $display("FAIL rnd_fwd0 c%0d: got %0d want %0d", c, fwd_sel[1:0], exp_fwd(0)); else passed++;
      checks++; if (fwd_sel[3:2] !== 2'(exp_fwd(1))) $display("FAIL rnd_fwd1 c%0d: got %0d want %0d", c, fwd_sel[3:2], exp_fwd(1)); else passed++;
      checks++; if (stall_cnt !== 16'(m_cnt)) $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cnt, m_cnt); else passed++;
      held = exp_stall();
      tick();
    end
    idle();
  endtask

  // Deep pipe (LOAD_STAGE=7): each load followed by a consumer yields 6 stalls.
  task automatic test_saturation();
    s_rst = 1'b1; #2; @(negedge clk); s_rst = 1'b0; @(posedge clk); #1;
    for (int g = 0; g < 11667; g++) begin
      s_id_valid = 1'b1; s_id_src = '0; s_id_dst = 5'd2; s_id_wr = 1'b1; s_id_load = 1'b1;
      @(posedge clk); #1;
      s_id_src = {5'd2, 5'd2}; s_id_dst = 5'd6; s_id_load = 1'b0;
      if (g == 0) begin
        #1;
        checks++; if (s_stall !== 1'b1) $display("FAIL sat_first_stall: got %0b want 1", s_stall); else passed++;
      end
      for (int j = 0; j < 6; j++) begin @(posedge clk); #1; end
      if (g == 0) begin
        checks++; if (s_stall !== 1'b0) $display("FAIL sat_stall_ends: got %0b want 0", s_stall); else passed++;
        checks++; if (s_stall_cnt !== 16'd6) $display("FAIL sat_cnt_6: got %0d want 6", s_stall_cnt); else passed++;
      end
      if (g == 10921) begin
        checks++; if (s_stall_cnt !== 16'd65532) $display("FAIL sat_cnt_65532: got %0d want 65532", s_stall_cnt); else passed++;
      end
    end
    s_id_valid = 1'b0;
    checks++; if (s_stall_cnt !== 16'hFFFF) $display("FAIL sat_cnt_max: got %0h want ffff", s_stall_cnt); else passed++;
    checks++; if (s_fwd_sel !== 6'h0) $display("FAIL sat_fwd: got %0h want 0", s_fwd_sel); else passed++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_raw_ex();
    test_load_use();
    test_youngest();
    test_distance();
    test_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 Parameter DEPTH, default 4, tracked stages (0=EX, 1=MEM, 2=WB, 3=REG-writeback); legal range 2..8.
REQ-004 Parameter LOAD_STAGE, default 2, first stage index at which load data is forwardable; legal range 1..DEPTH-1.
REQ-005 Parameter SEL_W, default $clog2(DEPTH), forward-select width.
REQ-006 clk  input  1  single clock; one clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 id_valid  input  1  ID holds a real instruction.
REQ-009 id_src  input  NUM_SRC*REG_AW  ID source register addresses, operand i at bits [i*REG_AW +: REG_AW].
REQ-010 id_dst  input  REG_AW  ID destination register.
REQ-011 id_wr  input  1  ID instruction writes id_dst.
REQ-012 id_load  input  1  ID instruction is a load.
REQ-013 flush  input  1  kill ID instruction and EX (stage 0) instruction.
REQ-014 stall  output  1  hold PC/IF/ID, insert bubble into EX.
REQ-015 fwd_sel  output  NUM_SRC*SEL_W  per EX operand: 0=register file, k=forward from stage k.
REQ-016 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 Scoreboard holds DEPTH entries {valid, wr, load, dst}; entry k is the instruction in stage k.
REQ-018 Each clock, entries k=1..DEPTH-1 load entry k-1; oldest entry is discarded.
REQ-019 Entry 0 loads the ID instruction, with its NUM_SRC sources latched to internal ex_src, when id_valid=1, stall=0, flush=0; otherwise entry 0 loads a bubble (valid=0, wr=0) and ex_src loads zero.
REQ-020 flush=1 also invalidates the current entry 0 before it shifts, so stage 1 receives a bubble next cycle.
REQ-021 A producer entry k matches source s when valid=1, wr=1, dst==s and s!=0; register 0 is never forwarded or stalled on, per operand.
REQ-022 fwd_sel for operand i is combinational: the smallest k in 1..DEPTH-1 whose entry matches ex_src[i] (youngest wins); 0 if none.
REQ-023 A matching load entry at k<LOAD_STAGE is not selected; the older match is used instead (unreachable when stall logic is correct; assertion target).
REQ-024 stall is combinational: 1 when id_valid=1, flush=0, and some id_src operand matches a load entry at index k with k+1<LOAD_STAGE.
REQ-025 With LOAD_STAGE=2, a load in EX followed by a dependent instruction gives exactly one stall cycle; LOAD_STAGE=3 gives two.
REQ-026 Stall and flush in the same cycle: flush wins, stall=0.
REQ-027 Both operands matching different stages select independently; same-register operands get identical selects.
REQ-028 stall_cnt increments on every clock with stall=1; holds at 16'hFFFF.

Reset
REQ-029 rst=1 immediately clears all entries to invalid, ex_src to 0, and stall_cnt to 0; stall=0 and fwd_sel=0 while rst=1.
REQ-030 Reset mid-stall drops the stall; first post-reset ID instruction enters EX with no forwarding.

Structure
REQ-031 A shared package holds the scoreboard entry struct, the FWD_RF=0 select constant and the DEPTH/LOAD_STAGE legality checks.
REQ-032 One sub-module, fwd_match, is instantiated per operand: given one source address and the entry vector, it returns the select value and a load-hazard flag.

Verification
REQ-033 add r3 then sub r4,r3,r5 back-to-back -> next cycle, when sub is in EX, fwd_sel[op0]=1, stall=0.
REQ-034 lw r2 then add r6,r2,r2 -> stall=1 for one cycle, then fwd_sel[op0]=fwd_sel[op1]=2; stall_cnt=1.
REQ-035 add r7, add r7, or r8,r7,r0 -> fwd_sel[op0]=1 (youngest), fwd_sel[op1]=0 (r0).
REQ-036 Write r9 three instructions before use (DEPTH=4) -> fwd_sel=3; four before -> fwd_sel=0.
REQ-037 lw r2 with flush asserted while the dependent instruction is in ID -> stall=0, stage 1 bubble, no forward next cycle.
REQ-038 Assert rst during the load-use stall -> stall=0, fwd_sel=0, stall_cnt=0 at once; saturation test: 70000 forced stalls -> stall_cnt=16'hFFFF.
